// File: rtl/uart_rx_pkg.sv
// UART receiver shared types: FSM state enum, baud/parity codes,
// and the rounded clock divisor helper. Imported by all rx files.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam logic [1:0] BAUD_2400  = 2'b00;
  localparam logic [1:0] BAUD_4800  = 2'b01;
  localparam logic [1:0] BAUD_9600  = 2'b10;
  localparam logic [1:0] BAUD_19200 = 2'b11;

  localparam logic [1:0] PAR_NONE  = 2'b00;
  localparam logic [1:0] PAR_ODD   = 2'b01;
  localparam logic [1:0] PAR_EVEN  = 2'b10;
  localparam logic [1:0] PAR_NONE3 = 2'b11;

  localparam int DIV_W = 16;

  function automatic int baud_hz(
    input logic [1:0] code
  );
    case (code)
      BAUD_2400:  return 2400;
      BAUD_4800:  return 4800;
      BAUD_9600:  return 9600;
      default:    return 19200;
    endcase
  endfunction

  // Clocks per sample tick, rounded to nearest.
  function automatic logic [DIV_W-1:0] baud_div(
    input int         clk_hz,
    input int         os,
    input logic [1:0] code
  );
    int d;
    d = baud_hz(code) * os;
    return DIV_W'((clk_hz + d / 2) / d);
  endfunction

endpackage

// File: rtl/uart_rx_baud_gen.sv
// Oversample tick generator: one-cycle tick every divisor clocks.
// Ports: clk, reset (sync, high), clear (restart count), sel, tick.
module uart_rx_baud_gen
  import uart_rx_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic [1:0] sel,
  output logic       tick
);

  localparam logic [DIV_W-1:0] LIM0 =
    baud_div(CLK_HZ, OVERSAMPLE, BAUD_2400) - 1'b1;
  localparam logic [DIV_W-1:0] LIM1 =
    baud_div(CLK_HZ, OVERSAMPLE, BAUD_4800) - 1'b1;
  localparam logic [DIV_W-1:0] LIM2 =
    baud_div(CLK_HZ, OVERSAMPLE, BAUD_9600) - 1'b1;
  localparam logic [DIV_W-1:0] LIM3 =
    baud_div(CLK_HZ, OVERSAMPLE, BAUD_19200) - 1'b1;

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] lim;

  always_comb begin
    lim = LIM0;
    unique case (sel)
      BAUD_2400:  lim = LIM0;
      BAUD_4800:  lim = LIM1;
      BAUD_9600:  lim = LIM2;
      BAUD_19200: lim = LIM3;
      default:    lim = LIM0;
    endcase
  end

  assign tick = (cnt == lim);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_top_module.sv
// UART receiver: 8 data bits, optional odd/even parity, 1 stop bit.
// Ports: clk, reset (sync, high), enable, baud_rate, parity_type, rx
//   in; dout, done (1-clk pulse), parity_err, frame_err, receiving out.
// Build option UART_RX_MAJORITY_EN: 2-of-3 vote over ticks 6,7,8.
module uart_rx_top_module
  import uart_rx_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [1:0] baud_rate,
  input  logic [1:0] parity_type,
  input  logic       rx,
  output logic [7:0] dout,
  output logic       done,
  output logic       parity_err,
  output logic       frame_err,
  output logic       receiving
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] LAST = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] MID  = TW'(OVERSAMPLE / 2 - 1);

`ifdef UART_RX_MAJORITY_EN
  // Vote completes on the tick after mid-bit.
  localparam logic [TW-1:0] DECIDE = MID + 1'b1;
`else
  localparam logic [TW-1:0] DECIDE = MID;
`endif

  state_t state, next;

  logic          sync1, rx_s, rx_prev;
  logic          tick;
  logic [TW-1:0] tick_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic [1:0]    baud_q, par_q;
  logic          par_bit;
  logic          par_en;
  logic          sample;
  logic          bit_val;
  logic          go;
  logic          fin;

  // Edge detect works on the synchronized line only.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1   <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      sync1   <= rx;
      rx_s    <= sync1;
      rx_prev <= rx_s;
    end
  end

  uart_rx_baud_gen #(
    .CLK_HZ     (CLK_HZ),
    .OVERSAMPLE (OVERSAMPLE)
  ) u_baud (
    .clk   (clk),
    .reset (reset),
    .clear (go),
    .sel   (baud_q),
    .tick  (tick)
  );

`ifdef UART_RX_MAJORITY_EN
  localparam logic [TW-1:0] MID_LO = MID - 1'b1;

  logic s_a, s_b;

  always_ff @(posedge clk) begin
    if (reset) begin
      s_a <= 1'b1;
      s_b <= 1'b1;
    end else if (tick) begin
      if (tick_cnt == MID_LO) s_a <= rx_s;
      if (tick_cnt == MID)    s_b <= rx_s;
    end
  end

  assign bit_val = (s_a & s_b) | (s_a & rx_s) | (s_b & rx_s);
`else
  assign bit_val = rx_s;
`endif

  assign par_en = (par_q == PAR_ODD) || (par_q == PAR_EVEN);
  assign sample = tick && (tick_cnt == DECIDE);
  assign receiving = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next;
    end
  end

  always_comb begin
    next = state;
    go   = 1'b0;
    fin  = 1'b0;
    if (!enable) begin
      next = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (rx_prev && !rx_s) begin
            next = START;
            go   = 1'b1;
          end
        end
        START: begin
          if (sample) next = bit_val ? IDLE : DATA;
        end
        DATA: begin
          if (sample && bit_cnt == 3'd7) begin
            next = par_en ? PARITY : STOP;
          end
        end
        PARITY: begin
          if (sample) next = STOP;
        end
        STOP: begin
          if (sample) begin
            next = IDLE;
            fin  = 1'b1;
          end
        end
        default: next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt   <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      baud_q     <= BAUD_2400;
      par_q      <= PAR_NONE;
      par_bit    <= 1'b0;
      dout       <= 8'h00;
      done       <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (go) begin
        baud_q   <= baud_rate;
        par_q    <= parity_type;
        tick_cnt <= '0;
        bit_cnt  <= '0;
      end else if (tick) begin
        tick_cnt <= (tick_cnt == LAST) ? '0 : tick_cnt + 1'b1;
      end
      if (state == DATA && sample) begin
        shreg   <= {bit_val, shreg[7:1]};
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (state == PARITY && sample) begin
        par_bit <= bit_val;
      end
      if (fin) begin
        done       <= 1'b1;
        dout       <= shreg;
        frame_err  <= ~bit_val;
        // Even code wants XOR(data); odd wants its inverse.
        parity_err <= par_en &
          (par_bit ^ (^shreg) ^ (par_q == PAR_ODD));
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_top_module.sv
// Self-checking bench for uart_rx_top_module.
// One clk period (10 units) stands for 1/CLK_HZ.
module tb_uart_rx_top_module;
  import uart_rx_pkg::*;

  localparam int CLK_HZ = 614_400;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b1;
  logic [1:0] baud_rate = 2'b00;
  logic [1:0] parity_type = 2'b00;
  logic       rx = 1'b1;
  logic [7:0] dout;
  logic       done, parity_err, frame_err, receiving;

  uart_rx_top_module #(
    .CLK_HZ     (CLK_HZ),
    .OVERSAMPLE (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .baud_rate   (baud_rate),
    .parity_type (parity_type),
    .rx          (rx),
    .dout        (dout),
    .done        (done),
    .parity_err  (parity_err),
    .frame_err   (frame_err),
    .receiving   (receiving)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  exp_t sb[$];

  typedef struct {
    logic [7:0] data;
    logic [1:0] bcode;
    logic [1:0] ptype;
    logic       pbit;
    logic       stop;
    logic       en;
    logic       scr;
    logic       epe;
    logic       efe;
  } vec_t;

  vec_t tbl[9];

  task automatic check(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int bit_clks(input logic [1:0] c);
    return CLK_HZ / (2400 * (1 << c));
  endfunction

  always @(negedge clk) begin : mon
    exp_t e;
    if (done === 1'b1) begin
      done_cnt++;
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: dout %0h", dout);
      end else begin
        e = sb.pop_front();
        check("dout", dout, e.d);
        check("parity_err", parity_err, e.pe);
        check("frame_err", frame_err, e.fe);
      end
    end
  end

  // Drives a frame clock by clock; cut>=0 stops after cut clocks.
  task automatic send(
    input logic [7:0] data,
    input logic [1:0] bcode,
    input logic [1:0] ptype,
    input logic       pbit,
    input logic       stop,
    input bit         expect_done,
    input exp_t       e,
    input bit         scr,
    input bit         spike,
    input bit         hold_low,
    input int         cut
  );
    int bc, tk, n, k;
    logic [10:0] bits;
    bit sp;
    bc = bit_clks(bcode);
    tk = bc / 16;
    bits = '1;
    bits[0] = 1'b0;
    bits[8:1] = data;
    n = 9;
    if (ptype == 2'b01 || ptype == 2'b10) begin
      bits[9] = pbit;
      n = 10;
    end
    bits[n] = stop;
    n++;
    @(negedge clk);
    baud_rate = bcode;
    parity_type = ptype;
    if (expect_done) sb.push_back(e);
    k = 0;
    for (int b = 0; b < n; b++) begin
      for (int i = 0; i < bc; i++) begin
        if (cut >= 0 && k >= cut) return;
        @(negedge clk);
        sp = spike && (i >= 8 * tk - tk / 2)
                   && (i < 8 * tk + tk / 2);
        rx = bits[b] ^ sp;
        if (scr && b == 1 && i == 0) begin
          baud_rate = ~bcode;
          parity_type = ~ptype;
        end
        k++;
      end
    end
    @(negedge clk);
    rx = hold_low ? 1'b0 : 1'b1;
  endtask

  task automatic drain(input string nm, input int bound);
    for (int k = 0; k < bound && sb.size() != 0; k++) begin
      @(negedge clk);
    end
    check(nm, sb.size(), 0);
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : main
    exp_t e;
    int dc, bc, hi;
    logic [7:0] prev;

    tbl[0] = '{8'hA5, 2'b00, 2'b10, 1'b0, 1'b1, 1, 0, 0, 0};
    tbl[1] = '{8'h3C, 2'b11, 2'b01, 1'b0, 1'b1, 1, 0, 1, 0};
    tbl[2] = '{8'h3C, 2'b11, 2'b01, 1'b1, 1'b1, 1, 0, 0, 0};
    tbl[3] = '{8'h00, 2'b10, 2'b00, 1'b0, 1'b1, 1, 0, 0, 0};
    tbl[4] = '{8'h81, 2'b01, 2'b10, 1'b1, 1'b1, 1, 0, 1, 0};
    tbl[5] = '{8'h7E, 2'b10, 2'b11, 1'b0, 1'b1, 1, 1, 0, 0};
    tbl[6] = '{8'hC3, 2'b00, 2'b01, 1'b1, 1'b0, 1, 1, 0, 1};
    tbl[7] = '{8'h12, 2'b11, 2'b10, 1'b0, 1'b1, 0, 0, 0, 0};
    tbl[8] = '{8'h01, 2'b11, 2'b10, 1'b1, 1'b1, 1, 0, 0, 0};

    check("div_2400", baud_div(50_000_000, 16, 2'b00), 1302);
    check("div_4800", baud_div(50_000_000, 16, 2'b01), 651);
    check("div_9600", baud_div(50_000_000, 16, 2'b10), 326);
    check("div_19200", baud_div(50_000_000, 16, 2'b11), 163);

    repeat (4) @(negedge clk);
    check("rst_dout", dout, 8'h00);
    check("rst_done", done, 1'b0);
    check("rst_perr", parity_err, 1'b0);
    check("rst_ferr", frame_err, 1'b0);
    check("rst_recv", receiving, 1'b0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    for (int v = 0; v < 9; v++) begin
      e.d = tbl[v].data;
      e.pe = tbl[v].epe;
      e.fe = tbl[v].efe;
      dc = done_cnt;
      prev = dout;
      enable = tbl[v].en;
      send(tbl[v].data, tbl[v].bcode, tbl[v].ptype,
           tbl[v].pbit, tbl[v].stop, tbl[v].en, e,
           tbl[v].scr, 0, 0, -1);
      bc = bit_clks(tbl[v].bcode);
      drain($sformatf("drain_%0d", v), 2 * bc);
      repeat (bc) @(negedge clk);
      check($sformatf("done_cnt_%0d", v), done_cnt - dc,
            tbl[v].en ? 1 : 0);
      if (!tbl[v].en) check("dis_dout", dout, prev);
      enable = 1'b1;
    end

    // Stop bit low, line stays low: one done, no restart.
    e = '{8'hFF, 1'b0, 1'b1};
    dc = done_cnt;
    send(8'hFF, 2'b11, 2'b00, 1'b0, 1'b0, 1, e, 0, 0, 1, -1);
    drain("drain_ff", 64);
    hi = 0;
    repeat (3 * 11 * 32) begin
      @(negedge clk);
      if (receiving !== 1'b0) hi++;
    end
    check("hold_low_recv", hi, 0);
    check("hold_low_done", done_cnt - dc, 1);
    rx = 1'b1;
    repeat (64) @(negedge clk);

    // ~2 us glitch on an idle line.
    prev = dout;
    dc = done_cnt;
    baud_rate = 2'b11;
    @(negedge clk);
    rx = 1'b0;
    #12;
    rx = 1'b1;
    hi = 0;
    for (int k = 0; k < 8 && hi == 0; k++) begin
      @(negedge clk);
      if (receiving === 1'b1) hi = 1;
    end
    check("glitch_recv_hi", hi, 1);
    for (int k = 0; k < 64 && receiving !== 1'b0; k++) begin
      @(negedge clk);
    end
    check("glitch_recv_lo", receiving, 1'b0);
    repeat (64) @(negedge clk);
    check("glitch_done", done_cnt - dc, 0);
    check("glitch_dout", dout, prev);

    // enable drop inside data bit 4 of 0x55.
    prev = dout;
    dc = done_cnt;
    send(8'h55, 2'b10, 2'b00, 1'b0, 1'b1, 0, e, 0, 0, 0,
         5 * 64 + 32);
    check("en_abort_busy", receiving, 1'b1);
    enable = 1'b0;
    @(negedge clk);
    check("en_abort_recv", receiving, 1'b0);
    rx = 1'b1;
    enable = 1'b1;
    repeat (12 * 64) @(negedge clk);
    check("en_abort_done", done_cnt - dc, 0);
    check("en_abort_dout", dout, prev);
    check("en_abort_idle", receiving, 1'b0);

    // reset inside data bit 4 of 0x55.
    dc = done_cnt;
    send(8'h55, 2'b10, 2'b00, 1'b0, 1'b1, 0, e, 0, 0, 0,
         5 * 64 + 32);
    check("rs_abort_busy", receiving, 1'b1);
    reset = 1'b1;
    rx = 1'b1;
    @(negedge clk);
    check("rs_abort_recv", receiving, 1'b0);
    check("rs_abort_dout", dout, 8'h00);
    check("rs_abort_perr", parity_err, 1'b0);
    check("rs_abort_ferr", frame_err, 1'b0);
    reset = 1'b0;
    repeat (12 * 64) @(negedge clk);
    check("rs_abort_done", done_cnt - dc, 0);

`ifdef UART_RX_MAJORITY_EN
    e = '{8'h5A, 1'b0, 1'b0};
    send(8'h5A, 2'b10, 2'b00, 1'b0, 1'b1, 1, e, 0, 1, 0, -1);
    drain("drain_maj", 128);
    repeat (64) @(negedge clk);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
